// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with a clear sweep.
// Outputs are registered and feed WRITE/INADDRESS/IN directly.
module reg_write_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_DATA,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_DATA,
  output logic              REQ1_READY,
  input  logic              CLEAR_START,
  output logic              CLEAR_BUSY,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              ptr;
  logic              idle;
  logic              clr_go;
  logic              arb_ok;

  assign idle   = (state == IDLE);
  assign clr_go = idle && CLEAR_START
                  && !CLEAR_BUSY;
  assign arb_ok = RESET && idle && !clr_go;

  assign REQ0_READY = arb_ok && REQ0_VALID
                      && (!REQ1_VALID || !ptr);
  assign REQ1_READY = arb_ok && REQ1_VALID
                      && (!REQ0_VALID || ptr);

  // Sweep sequencer: IDLE -> CLEAR, then one
  // address per cycle until the last register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST)
        state <= IDLE;
    end else if (clr_go) begin
      state <= CLEAR;
      cnt   <= '0;
    end
  end

  // Priority pointer flips to the other side
  // after every grant; a clear leaves it alone.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      ptr <= 1'b0;
    else if (REQ0_READY)
      ptr <= 1'b1;
    else if (REQ1_READY)
      ptr <= 1'b0;
  end

  // Registered write port; address and data
  // hold when no write is issued.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WRITE      <= 1'b0;
      INADDRESS  <= '0;
      IN         <= '0;
      CLEAR_BUSY <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == CLEAR): begin
          WRITE      <= 1'b1;
          INADDRESS  <= cnt;
          IN         <= '0;
          CLEAR_BUSY <= 1'b1;
        end
        REQ0_READY: begin
          WRITE      <= 1'b1;
          INADDRESS  <= REQ0_ADDR;
          IN         <= REQ0_DATA;
          CLEAR_BUSY <= 1'b0;
        end
        REQ1_READY: begin
          WRITE      <= 1'b1;
          INADDRESS  <= REQ1_ADDR;
          IN         <= REQ1_DATA;
          CLEAR_BUSY <= 1'b0;
        end
        default: begin
          WRITE      <= 1'b0;
          CLEAR_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter.
// Directed scenarios plus random traffic against a transaction-level model.
module tb_reg_write_arbiter;

  localparam int NUM = 8;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } txn_t;

  logic       CLK = 1'b1;
  logic       RESET;
  logic       REQ0_VALID, REQ1_VALID;
  logic [2:0] REQ0_ADDR, REQ1_ADDR;
  logic [7:0] REQ0_DATA, REQ1_DATA;
  logic       REQ0_READY, REQ1_READY;
  logic       CLEAR_START, CLEAR_BUSY;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;

  reg_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID),
    .REQ0_ADDR(REQ0_ADDR),
    .REQ0_DATA(REQ0_DATA),
    .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID),
    .REQ1_ADDR(REQ1_ADDR),
    .REQ1_DATA(REQ1_DATA),
    .REQ1_READY(REQ1_READY),
    .CLEAR_START(CLEAR_START),
    .CLEAR_BUSY(CLEAR_BUSY),
    .WRITE(WRITE),
    .INADDRESS(INADDRESS),
    .IN(IN)
  );

  always #5 CLK = ~CLK;

  // Register file fed by the DUT's write port.
  logic [7:0] rf [NUM];
  always @(posedge CLK)
    if (WRITE === 1'b1) rf[INADDRESS] <= IN;

  int total = 0;
  int bad   = 0;

  // Requester queues and stimulus controls.
  txn_t q0[$];
  txn_t q1[$];
  logic cs;
  int   glog[$];

  // Reference model state.
  int         sweep_left;
  int         sweep_idx;
  int         turn;
  logic       e_wr;
  logic [2:0] e_addr;
  logic [7:0] e_data;
  logic       e_busy;
  logic [7:0] exp_rf [NUM];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sweep_left = 0;
    sweep_idx  = 0;
    turn       = 0;
    e_wr       = 1'b0;
    e_addr     = '0;
    e_data     = '0;
    e_busy     = 1'b0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_write"}, WRITE, e_wr);
    chk({tag, "_addr"}, INADDRESS, e_addr);
    chk({tag, "_data"}, IN, e_data);
    chk({tag, "_busy"}, CLEAR_BUSY, e_busy);
  endtask

  // One clock cycle: drive, check READYs, advance model, check outputs.
  task automatic cycle(input string tag);
    logic v0, v1, ok, g0, g1;
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    REQ0_VALID  = v0;
    REQ1_VALID  = v1;
    REQ0_ADDR   = v0 ? q0[0].a : 3'd0;
    REQ0_DATA   = v0 ? q0[0].d : 8'd0;
    REQ1_ADDR   = v1 ? q1[0].a : 3'd0;
    REQ1_DATA   = v1 ? q1[0].d : 8'd0;
    CLEAR_START = cs;
    @(negedge CLK);
    ok = RESET && sweep_left == 0 && !(cs && !e_busy);
    g0 = ok && v0 && (!v1 || turn == 0);
    g1 = ok && v1 && (!v0 || turn == 1);
    chk({tag, "_rdy0"}, REQ0_READY, g0);
    chk({tag, "_rdy1"}, REQ1_READY, g1);
    @(posedge CLK);
    if (!RESET) begin
      model_reset();
    end else begin
      if (e_wr) exp_rf[e_addr] = e_data;
      if (sweep_left > 0) begin
        e_wr   = 1'b1;
        e_addr = 3'(sweep_idx);
        e_data = 8'h00;
        e_busy = 1'b1;
        sweep_idx++;
        sweep_left--;
      end else if (cs && !e_busy) begin
        sweep_left = NUM;
        sweep_idx  = 0;
        e_wr       = 1'b0;
        e_busy     = 1'b0;
      end else if (g0) begin
        e_wr = 1'b1; e_addr = q0[0].a;
        e_data = q0[0].d; e_busy = 1'b0;
        void'(q0.pop_front());
        turn = 1; glog.push_back(0);
      end else if (g1) begin
        e_wr = 1'b1; e_addr = q1[0].a;
        e_data = q1[0].d; e_busy = 1'b0;
        void'(q1.pop_front());
        turn = 0; glog.push_back(1);
      end else begin
        e_wr = 1'b0; e_busy = 1'b0;
      end
    end
    #1;
    chk_outs(tag);
  endtask

  // Assert reset between clock edges and check the immediate effect.
  task automatic async_reset(input string tag);
    #2;
    RESET = 1'b0;
    #1;
    model_reset();
    chk({tag, "_w0"}, WRITE, 1'b0);
    chk({tag, "_a0"}, INADDRESS, 3'd0);
    chk({tag, "_d0"}, IN, 8'd0);
    chk({tag, "_b0"}, CLEAR_BUSY, 1'b0);
    chk({tag, "_r0"}, REQ0_READY, 1'b0);
    chk({tag, "_r1"}, REQ1_READY, 1'b0);
  endtask

  initial begin
    int busy_n;
    RESET = 1'b0;
    cs    = 1'b0;
    REQ0_VALID = 0; REQ1_VALID = 0;
    REQ0_ADDR = 0; REQ1_ADDR = 0;
    REQ0_DATA = 0; REQ1_DATA = 0;
    CLEAR_START = 0;
    model_reset();
    for (int i = 0; i < NUM; i++) begin
      rf[i] = 8'h00; exp_rf[i] = 8'h00;
    end
    #1;
    chk_outs("por");
    cycle("por");
    RESET = 1'b1;

    // Single write from REQ0.
    q0.push_back('{3'd3, 8'h5A});
    cycle("t2");
    chk("t2_write", WRITE, 1'b1);
    chk("t2_addr", INADDRESS, 3'd3);
    chk("t2_in", IN, 8'h5A);
    cycle("t2b");
    chk("t2_idle", WRITE, 1'b0);
    chk("t2_rf3", rf[3], 8'h5A);

    // Lone REQ1 write hands the pointer back to REQ0.
    q1.push_back('{3'd6, 8'h66});
    cycle("lone1");
    cycle("lone1b");

    // Contention: four alternating grants.
    glog.delete();
    q0.push_back('{3'd1, 8'h11});
    q0.push_back('{3'd1, 8'h12});
    q1.push_back('{3'd2, 8'h22});
    q1.push_back('{3'd2, 8'h23});
    for (int i = 0; i < 4; i++) begin
      cycle("t3");
      chk("t3_wr", WRITE, 1'b1);
    end
    chk("t3_ngnt", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("t3_order", glog[i], i % 2);
    cycle("t3e");
    chk("t3_rf1", rf[1], 8'h12);
    chk("t3_rf2", rf[2], 8'h23);

    // Clear sweep.
    cs = 1'b1;
    cycle("t4s");
    cs = 1'b0;
    busy_n = 0;
    for (int i = 0; i < NUM + 2; i++) begin
      cycle("t4");
      if (CLEAR_BUSY === 1'b1) busy_n++;
    end
    chk("t4_busyn", busy_n, NUM);
    for (int i = 0; i < NUM; i++)
      chk("t4_rf", rf[i], 8'h00);

    // Clear collides with a pending REQ1 write.
    q1.push_back('{3'd5, 8'hC3});
    cs = 1'b1;
    cycle("t5s");
    cs = 1'b0;
    for (int i = 0; i < NUM + 3; i++) cycle("t5");
    chk("t5_q1", q1.size(), 0);
    chk("t5_rf5", rf[5], 8'hC3);

    // Mid-stream reset with a write on the port.
    q0.push_back('{3'd7, 8'hFF});
    cycle("t1a");
    chk("t1_pre", WRITE, 1'b1);
    async_reset("t1");
    cycle("t1r");
    RESET = 1'b1;
    cycle("t1p");

    // Reset in the middle of a sweep.
    cs = 1'b1;
    cycle("t6s");
    cs = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (e_busy && e_addr == 3'd4) break;
      cycle("t6");
    end
    chk("t6_at4", INADDRESS, 3'd4);
    async_reset("t6");
    cycle("t6r");
    RESET = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle("t6p");
      chk("t6_nowr", WRITE, 1'b0);
      chk("t6_nobusy", CLEAR_BUSY, 1'b0);
    end

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0)
        q0.push_back('{3'($urandom), 8'($urandom)});
      if (q1.size() < 3 && $urandom_range(0, 2) == 0)
        q1.push_back('{3'($urandom), 8'($urandom)});
      cs = ($urandom_range(0, 24) == 0);
      cycle("rnd");
    end
    cs = 1'b0;
    for (int i = 0; i < 20; i++) cycle("drain");
    for (int i = 0; i < NUM; i++)
      chk("rnd_rf", rf[i], exp_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
